// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
//   Shared types and constants for the data-memory arbiter slice:
//   bus widths, memory strobe levels, master IDs, round-robin state encodings
//   and the issue-register record.
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

  localparam int REG_W  = 32;  // data bus width
  localparam int ADDR_W = 5;   // word address width

  typedef logic [REG_W-1:0]  reg_t;
  typedef logic [ADDR_W-1:0] addr_t;

  // Memory strobe levels
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic READ_ENABLE   = 1'b1;
  localparam logic READ_DISABLE  = 1'b0;

  // Master IDs: m0 = core load/store unit, m1 = debug/DMA port
  typedef enum logic {
    ARB_M0 = 1'b0,
    ARB_M1 = 1'b1
  } arb_id_e;

  // Round-robin priority state
  typedef enum logic {
    PRI_M0 = 1'b0,
    PRI_M1 = 1'b1
  } pri_e;

  // One-deep issue register contents
  typedef struct packed {
    logic    valid;
    arb_id_e id;
    logic    we;
    addr_t   addr;
    reg_t    wdata;
  } iss_t;

endpackage : dmem_arbiter_pkg

// File: rtl/dmem_arbiter_rr_picker.sv
// -----------------------------------------------------------------------------
// dmem_rr_picker
//   Two-way winner select for the data-memory arbiter.
//   ARB_MODE=0: round-robin FSM (PRI_M0 / PRI_M1), priority moves to the
//               master that was not granted.
//   ARB_MODE=1: fixed priority to m0, with a saturating starve counter that
//               forces an m1 grant after STARVE_LIMIT waiting cycles.
// Ports
//   CLK     in   system clock, rising edge
//   RST     in   synchronous reset, active-high; forces gnt=0
//   req     in   [1:0] request per master
//   gnt     out  [1:0] one-hot (or zero) grant, combinational
//   win_id  out  id of the winning master (valid when |gnt)
// -----------------------------------------------------------------------------
module dmem_rr_picker
  import dmem_arbiter_pkg::*;
#(
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  output logic [1:0] gnt,
  output arb_id_e    win_id
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  pri_e       state, state_nxt;
  logic [3:0] starve, starve_nxt;
  logic       pick_m1;

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    gnt        = 2'b00;
    win_id     = ARB_M0;
    pick_m1    = 1'b0;
    state_nxt  = state;
    starve_nxt = starve;

    if (ARB_MODE == 0) begin
      // m1 wins when it is the only requester, or on a tie while it holds priority
      pick_m1 = req[1] && (!req[0] || (state == PRI_M1));
    end else begin
      // m1 wins when alone, or when it has waited long enough
      pick_m1 = req[1] && (!req[0] || (starve == LIMIT));
    end

    if (!RST && (req != 2'b00)) begin
      if (pick_m1) begin
        gnt       = 2'b10;
        win_id    = ARB_M1;
        state_nxt = PRI_M0;
      end else begin
        gnt       = 2'b01;
        win_id    = ARB_M0;
        state_nxt = PRI_M1;
      end
    end

    if (gnt[1]) begin
      starve_nxt = 4'd0;
    end else if (req[1] && (starve < LIMIT)) begin
      starve_nxt = starve + 4'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= PRI_M0;
      starve <= 4'd0;
    end else begin
      state  <= state_nxt;
      starve <= starve_nxt;
    end
  end

endmodule : dmem_rr_picker

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-master request/grant arbiter in front of the single-port data memory.
//   One request per cycle is accepted into a one-deep issue register that
//   drives the memory ports on the following cycle; read data is registered
//   and returned to the owning master with a one-cycle rvalid pulse.
// Ports
//   CLK, RST                 clock (rising edge), synchronous active-high reset
//   mN_req/we/addr/wdata     N=0,1 request; held with its fields until mN_gnt
//   mN_gnt                   request accepted this cycle (combinational)
//   mN_rvalid, mN_rdata      read response; rdata held until the next one
//   mem_WRn, mem_RDn         memory write / read strobes
//   mem_addr, mem_DIN        memory address / write data
//   mem_DOUT                 memory read data, combinational from mem_addr
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  m0_req,
  input  logic  m0_we,
  input  addr_t m0_addr,
  input  reg_t  m0_wdata,
  output logic  m0_gnt,
  output logic  m0_rvalid,
  output reg_t  m0_rdata,
  input  logic  m1_req,
  input  logic  m1_we,
  input  addr_t m1_addr,
  input  reg_t  m1_wdata,
  output logic  m1_gnt,
  output logic  m1_rvalid,
  output reg_t  m1_rdata,
  output logic  mem_WRn,
  output logic  mem_RDn,
  output addr_t mem_addr,
  output reg_t  mem_DIN,
  input  reg_t  mem_DOUT
);

  logic [1:0]            gnt;
  arb_id_e               win_id;
  iss_t                  iss;
  logic                  sel_we;
  addr_t                 sel_addr;
  reg_t                  sel_wdata;
  logic [1:0]            rvalid_q;
  logic [1:0][REG_W-1:0] rdata_q;

  dmem_rr_picker #(
    .ARB_MODE     (ARB_MODE),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) u_picker (
    .CLK    (CLK),
    .RST    (RST),
    .req    ({m1_req, m0_req}),
    .gnt    (gnt),
    .win_id (win_id)
  );

  assign m0_gnt = gnt[0];
  assign m1_gnt = gnt[1];

  // Request fields of the winning master
  always_comb begin
    sel_we    = m0_we;
    sel_addr  = m0_addr;
    sel_wdata = m0_wdata;
    if (win_id == ARB_M1) begin
      sel_we    = m1_we;
      sel_addr  = m1_addr;
      sel_wdata = m1_wdata;
    end
  end

  // Issue register and read response registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      iss      <= '0;
      rvalid_q <= 2'b00;
      rdata_q  <= '0;
    end else begin
      iss.valid <= |gnt;
      iss.id    <= win_id;
      iss.we    <= sel_we;
      iss.addr  <= sel_addr;
      iss.wdata <= sel_wdata;

      rvalid_q <= 2'b00;
      if (iss.valid && !iss.we) begin
        rvalid_q[iss.id] <= 1'b1;
        rdata_q[iss.id]  <= mem_DOUT;
      end
    end
  end

  // Memory drive. Gating with RST drops a transaction whose issue cycle
  // coincides with reset, so its write never reaches the memory.
  always_comb begin
    mem_WRn  = WRITE_DISABLE;
    mem_RDn  = READ_DISABLE;
    mem_addr = '0;
    mem_DIN  = '0;
    if (!RST && iss.valid) begin
      mem_addr = iss.addr;
      if (iss.we) begin
        mem_WRn = WRITE_ENABLE;
        mem_DIN = iss.wdata;
      end else begin
        mem_RDn = READ_ENABLE;
      end
    end
  end

  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata_q[0];
  assign m1_rdata  = rdata_q[1];

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed bench for dmem_arbiter. Two instances share the master-side
//   stimulus: dut_a in round-robin mode, dut_b in fixed-priority mode with
//   STARVE_LIMIT=4. Each has its own word memory model; unwritten words read
//   as 32'hA000_0000 | address.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  logic  CLK;
  logic  RST;
  logic  m0_req, m0_we, m1_req, m1_we;
  addr_t m0_addr, m1_addr;
  reg_t  m0_wdata, m1_wdata;

  logic  a_gnt0, a_gnt1, a_rv0, a_rv1, a_wrn, a_rdn;
  reg_t  a_rdata0, a_rdata1, a_din, a_dout;
  addr_t a_addr;
  logic  b_gnt0, b_gnt1, b_rv0, b_rv1, b_wrn, b_rdn;
  reg_t  b_rdata0, b_rdata1, b_din, b_dout;
  addr_t b_addr;

  int n_checks = 0;
  int n_pass   = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  dmem_arbiter #(.ARB_MODE(0), .STARVE_LIMIT(4)) dut_a (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(a_gnt0), .m0_rvalid(a_rv0), .m0_rdata(a_rdata0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(a_gnt1), .m1_rvalid(a_rv1), .m1_rdata(a_rdata1),
    .mem_WRn(a_wrn), .mem_RDn(a_rdn), .mem_addr(a_addr), .mem_DIN(a_din),
    .mem_DOUT(a_dout)
  );

  dmem_arbiter #(.ARB_MODE(1), .STARVE_LIMIT(4)) dut_b (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(b_gnt0), .m0_rvalid(b_rv0), .m0_rdata(b_rdata0),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(b_gnt1), .m1_rvalid(b_rv1), .m1_rdata(b_rdata1),
    .mem_WRn(b_wrn), .mem_RDn(b_rdn), .mem_addr(b_addr), .mem_DIN(b_din),
    .mem_DOUT(b_dout)
  );

  // Memory models
  bit [31:0] mem_a [32];
  bit        vld_a [32];
  bit [31:0] mem_b [32];
  bit        vld_b [32];

  always @(posedge CLK) begin
    if (a_wrn == WRITE_ENABLE) begin
      mem_a[a_addr] <= a_din;
      vld_a[a_addr] <= 1'b1;
    end
    if (b_wrn == WRITE_ENABLE) begin
      mem_b[b_addr] <= b_din;
      vld_b[b_addr] <= 1'b1;
    end
  end

  assign a_dout = vld_a[a_addr] ? mem_a[a_addr] : (32'hA000_0000 | 32'(a_addr));
  assign b_dout = vld_b[b_addr] ? mem_b[b_addr] : (32'hA000_0000 | 32'(b_addr));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST      = 1'b1;
    m0_req   = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req   = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;

    // 1. Reset held for 3 cycles with both masters requesting
    m0_req = 1'b1;
    m1_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      #1;
      check("rst_a_gnt", {30'd0, a_gnt1, a_gnt0}, 32'd0);
      check("rst_b_gnt", {30'd0, b_gnt1, b_gnt0}, 32'd0);
      check("rst_rvalid", {28'd0, a_rv1, a_rv0, b_rv1, b_rv0}, 32'd0);
      check("rst_wrn", {31'd0, a_wrn}, {31'd0, WRITE_DISABLE});
    end

    // Release with both idle: ports idle
    step();
    RST = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    #1;
    check("idle_gnt", {30'd0, a_gnt1, a_gnt0}, 32'd0);
    check("idle_rdn", {31'd0, a_rdn}, {31'd0, READ_DISABLE});
    check("idle_addr", 32'(a_addr), 32'd0);

    // 2. m0 write then read of address 5
    step();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 5'd5; m0_wdata = 32'hDEAD_BEEF;
    #1;
    check("wr_gnt", {31'd0, a_gnt0}, 32'd1);
    step();
    m0_we = 1'b0;
    #1;
    check("rd_gnt", {31'd0, a_gnt0}, 32'd1);
    check("wr_wrn", {31'd0, a_wrn}, {31'd0, WRITE_ENABLE});
    check("wr_addr", 32'(a_addr), 32'd5);
    check("wr_din", a_din, 32'hDEAD_BEEF);
    step();
    m0_req = 1'b0;
    #1;
    check("rd_rdn", {31'd0, a_rdn}, {31'd0, READ_ENABLE});
    check("rd_wrn", {31'd0, a_wrn}, {31'd0, WRITE_DISABLE});
    step();
    #1;
    check("rd_rvalid0", {31'd0, a_rv0}, 32'd1);
    check("rd_rvalid1", {31'd0, a_rv1}, 32'd0);
    check("rd_rdata0", a_rdata0, 32'hDEAD_BEEF);
    step();
    #1;
    check("rd_pulse", {31'd0, a_rv0}, 32'd0);
    check("rd_hold", a_rdata0, 32'hDEAD_BEEF);

    // 3/4. Both masters reading continuously after a fresh reset
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    m0_we = 1'b0; m0_addr = 5'd2;
    m1_we = 1'b0; m1_addr = 5'd3;
    for (int i = 0; i < 12; i++) begin
      bit b_m1;
      bit exp_rv0;
      bit exp_rv1;
      step();
      m0_req = (i < 10);
      m1_req = (i < 10);
      #1;
      if (i < 10) begin
        check("rr_gnt0", {31'd0, a_gnt0}, {31'd0, (i % 2) == 0});
        check("rr_gnt1", {31'd0, a_gnt1}, {31'd0, (i % 2) == 1});
        b_m1 = ((i % 5) == 4);
        check("fp_gnt0", {31'd0, b_gnt0}, {31'd0, !b_m1});
        check("fp_gnt1", {31'd0, b_gnt1}, {31'd0, b_m1});
      end
      exp_rv0 = (i >= 2) && ((i % 2) == 0);
      exp_rv1 = (i >= 3) && ((i % 2) == 1);
      check("rr_rv0", {31'd0, a_rv0}, {31'd0, exp_rv0});
      check("rr_rv1", {31'd0, a_rv1}, {31'd0, exp_rv1});
      if (exp_rv0) check("rr_rdata0", a_rdata0, 32'hA000_0002);
      if (exp_rv1) check("rr_rdata1", a_rdata1, 32'hA000_0003);
    end

    // 5. m1 read granted, reset on its issue cycle
    step();
    m0_req = 1'b0; m1_req = 1'b1; m1_we = 1'b0; m1_addr = 5'd4;
    #1;
    check("r5_gnt1", {31'd0, a_gnt1}, 32'd1);
    check("r5_gnt0", {31'd0, a_gnt0}, 32'd0);
    step();
    RST = 1'b1; m1_req = 1'b0;
    #1;
    check("r5_rdn", {31'd0, a_rdn}, {31'd0, READ_DISABLE});
    check("r5_addr", 32'(a_addr), 32'd0);
    step();
    RST = 1'b0;
    #1;
    check("r5_rv1", {31'd0, a_rv1}, 32'd0);
    check("r5_rdata1", a_rdata1, 32'd0);
    step();
    #1;
    check("r5_rv1_late", {31'd0, a_rv1}, 32'd0);

    // 6. m0 write to address 7, reset on its issue cycle
    step();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 5'd7; m0_wdata = 32'h1234_5678;
    #1;
    check("r6_gnt0", {31'd0, a_gnt0}, 32'd1);
    step();
    RST = 1'b1; m0_req = 1'b0;
    #1;
    check("r6_wrn", {31'd0, a_wrn}, {31'd0, WRITE_DISABLE});
    check("r6_din", a_din, 32'd0);
    step();
    // Priority was with m1 before reset; it must be back with m0
    RST = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd7;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 5'd3;
    #1;
    check("r6_pri_gnt0", {31'd0, a_gnt0}, 32'd1);
    check("r6_pri_gnt1", {31'd0, a_gnt1}, 32'd0);
    step();
    m0_req = 1'b0;
    #1;
    check("r6_gnt1", {31'd0, a_gnt1}, 32'd1);
    step();
    m1_req = 1'b0;
    #1;
    check("r6_rv0", {31'd0, a_rv0}, 32'd1);
    check("r6_rdata0", a_rdata0, 32'hA000_0007);
    step();
    #1;
    check("r6_rv1", {31'd0, a_rv1}, 32'd1);
    check("r6_rdata1", a_rdata1, 32'hA000_0003);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_dmem_arbiter
